// File: rtl/usb_serial_tx_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// usb_serial_tx_arbiter: tagged, packet-granular round-robin mux of two byte
// streams onto one send channel.                               Rev 1.0
// ---------------------------------------------------------------------------
module usb_serial_tx_arbiter #(
  parameter int unsigned MAX_BURST    = 32,
  parameter int unsigned IDLE_TIMEOUT = 16,
  parameter bit          HEADER_EN    = 1'b1,
  parameter logic [7:0]  HDR0         = 8'hA0,
  parameter logic [7:0]  HDR1         = 8'hA1
) (
  input  logic       clk,
  input  logic       usb_rstn,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [7:0] c_cnt_last = 8'(MAX_BURST - 1);
  localparam logic [7:0] c_tmr_last = 8'(IDLE_TIMEOUT - 1);

  state_t     r_state, w_state_nxt;
  logic       r_gnt, w_gnt_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_tmr, w_tmr_nxt;
  logic       w_gnt_valid;
  logic [7:0] w_gnt_data;

  assign w_gnt_valid = r_gnt ? s1_valid : s0_valid;
  assign w_gnt_data  = r_gnt ? s1_data  : s0_data;

  // last resets to 1 so that source 0 wins the first contention
  always_ff @(posedge clk or negedge usb_rstn) begin
    if (!usb_rstn) begin
      r_state <= ST_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
      r_tmr   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;
    m_data      = 8'h00;
    m_valid     = 1'b0;
    s0_ready    = 1'b0;
    s1_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 8'd0;
        w_tmr_nxt = 8'd0;
        if (s0_valid | s1_valid) begin
          w_gnt_nxt   = (s0_valid & s1_valid) ? ~r_last : s1_valid;
          w_state_nxt = HEADER_EN ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        m_data  = r_gnt ? HDR1 : HDR0;
        m_valid = 1'b1;
        if (m_ready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        m_data   = w_gnt_data;
        m_valid  = w_gnt_valid;
        s0_ready = ~r_gnt & m_ready;
        s1_ready = r_gnt & m_ready;
        // a transfer always beats the idle timeout in the same cycle
        if (w_gnt_valid & m_ready) begin
          w_cnt_nxt = r_cnt + 8'd1;
          w_tmr_nxt = 8'd0;
          if (r_cnt == c_cnt_last) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_gnt;
          end
        end else if (!w_gnt_valid) begin
          if (r_tmr == c_tmr_last) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_gnt;
          end else begin
            w_tmr_nxt = r_tmr + 8'd1;
          end
        end else begin
          w_tmr_nxt = 8'd0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/usb_serial_tx_arbiter.md
# usb_serial_tx_arbiter

Packet-granular round-robin arbiter that shares one CDC send channel (the `sendN_data/valid/ready` byte stream of the USB-serial top) between two byte-stream producers. Each granted burst is prefixed by a one-byte source tag so the host can demultiplex. A burst ends when `MAX_BURST` bytes have been sent or the granted source stays idle for `IDLE_TIMEOUT` cycles. Sits between application producers and the send-buffer write port.

## Interface
- `MAX_BURST`, default 32: maximum payload bytes per burst. Legal range 1..255.
- `IDLE_TIMEOUT`, default 16: number of consecutive idle cycles of the granted source that ends a burst. Legal range 1..255.
- `HEADER_EN`, default 1: 1 = emit a tag byte at the start of each burst; 0 = no tag.
- `HDR0`, default 8'hA0: tag byte for source 0.
- `HDR1`, default 8'hA1: tag byte for source 1.

Ports:
- `clk` in 1: clock.
- `usb_rstn` in 1: reset, asynchronous, active-low.
- `s0_data` in 8: source 0 byte.
- `s0_valid` in 1: source 0 has a byte.
- `s0_ready` out 1: source 0 byte accepted when `s0_valid & s0_ready`.
- `s1_data`, `s1_valid`, `s1_ready`: same signals for source 1.
- `m_data` out 8: byte to the send channel.
- `m_valid` out 1: byte present on `m_data`.
- `m_ready` in 1: send channel accepts the byte when `m_valid & m_ready`.

## Operation
- Registered state:
  - FSM state: IDLE, HDR, DATA.
  - `gnt`: 1 bit, the granted source.
  - `last`: 1 bit, the source of the previous burst.
  - `cnt`: 8 bits, payload bytes sent in the current burst.
  - `tmr`: 8 bits, consecutive idle cycles of the granted source.
- IDLE:
  - `m_valid=0`, both `sX_ready=0`.
  - If exactly one `sX_valid=1`, set `gnt` to that source.
  - If both are valid, set `gnt=~last`.
  - Clear `cnt` and `tmr`.
  - Next state is HDR when `HEADER_EN=1`, otherwise DATA.
  - If neither source is valid, stay in IDLE.
- HDR:
  - `m_data` = HDR0 or HDR1 selected by `gnt`; `m_valid=1`; both `sX_ready=0`.
  - On `m_ready`, go to DATA.
  - If `m_ready=0`, hold; the tag stays stable.
- DATA, pass-through:
  - `m_data=s_gnt_data`, `m_valid=s_gnt_valid`, `s_gnt_ready=m_ready`.
  - The non-granted source's ready is 0.
  - On each transfer: `cnt++` and `tmr` clears.
  - On each cycle with `s_gnt_valid=0`: `tmr++`.
  - A transfer with `cnt==MAX_BURST-1` ends the burst.
  - `tmr` reaching `IDLE_TIMEOUT-1` with `s_gnt_valid=0` also ends the burst.
  - Ending a burst means: go to IDLE and set `last<=gnt`.
  - If a transfer and the timeout condition coincide, the transfer wins: the byte is passed, `tmr` clears, and the burst ends only if the `cnt` limit was hit.
  - A cycle with `s_gnt_valid=1, m_ready=0` is not idle: `tmr` clears.
- Sources may deassert valid without a transfer. The arbiter never drops or duplicates a byte.
- Fairness: with both sources continuously valid, grants strictly alternate.
- All outputs are combinational from registered state and the current inputs. There is no combinational path from `m_ready` to `m_valid`.

## Timing
- Reset values (async, when `usb_rstn=0`):
  - state IDLE, `gnt=0`, `last=1` (so source 0 wins the first contention), `cnt=0`, `tmr=0`.
  - `m_valid=0`, `m_data=8'h00`, `s0_ready=s1_ready=0`.
  - Leaving reset starts from IDLE.
  - Reset mid-burst abandons the burst. An unaccepted source byte stays owned by its source.
- Arbitration latency: source valid in cycle N in IDLE gives the tag with `m_valid=1` in N+1, and the first payload byte can transfer in N+2 at the earliest. With `HEADER_EN=0`, the payload can transfer in N+1.
- Between bursts there is 1 IDLE cycle with `m_valid=0`.
- Burst length on the channel is at most `MAX_BURST + HEADER_EN` bytes.
- In DATA, data and ready pass through with zero added latency.

## Test plan
- Only s0 sends 8'h11, 8'h22, 8'h33, then goes idle; `m_ready=1`; `IDLE_TIMEOUT=4`. Required: `m` carries A0, 11, 22, 33; the arbiter returns to IDLE exactly 4 idle cycles after the last byte.
- Both sources continuously valid with incrementing data; `MAX_BURST=4`. Required: A0 + 4 s0 bytes, IDLE, A1 + 4 s1 bytes, IDLE, A0 and so on; s0 is granted first after reset.
- Same as above, with `m_ready` random at 50%. Required: the scoreboard finds every source byte exactly once, in order, in its own tag's burst; `m_data`/`m_valid` stay stable while `m_ready=0`.
- s0 has a gap of `IDLE_TIMEOUT-1` cycles mid-stream. Required: no new tag. A gap of `IDLE_TIMEOUT` cycles: the burst closes, and the next byte is preceded by a fresh A0.
- `usb_rstn` pulsed low during the DATA state. Required: next cycle `m_valid=0` and both ready=0; after release, with both sources valid, s0 is granted and A0 is the first byte out.
- `HEADER_EN=0`, both sources valid, `MAX_BURST=2`. Required: 2 s0 bytes, 2 s1 bytes, alternating, with no tag bytes.
